// File: rtl/router_fsm.sv
// rtl/router_fsm.sv - write-side control FSM for the 1x3 packet router
module router_fsm (
   input  logic       clock,
   input  logic       resetn,
   input  logic       pkt_valid,
   input  logic [1:0] data_in,
   input  logic       parity_done,
   input  logic       low_pkt_valid,
   input  logic       fifo_full,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   input  logic       soft_reset_0,
   input  logic       soft_reset_1,
   input  logic       soft_reset_2,
   output logic       busy,
   output logic       detect_add,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       write_enb_reg,
   output logic       rst_int_reg
);

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      FIFO_FULL_STATE    = 3'd3,
      LOAD_AFTER_FULL    = 3'd4,
      LOAD_PARITY        = 3'd5,
      CHECK_PARITY_ERROR = 3'd6,
      WAIT_TILL_EMPTY    = 3'd7
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] addr_q, addr_d;
   logic       sel_soft_reset;
   logic       sel_empty_q;
   logic       hdr_empty;

   // Soft reset and the wait-till-empty release follow the latched port;
   // header decode uses the live address field.
   always_comb begin
      sel_soft_reset = 1'b0;
      sel_empty_q    = 1'b0;
      hdr_empty      = 1'b0;
      case (addr_q)
         2'd0:    begin sel_soft_reset = soft_reset_0; sel_empty_q = fifo_empty_0; end
         2'd1:    begin sel_soft_reset = soft_reset_1; sel_empty_q = fifo_empty_1; end
         2'd2:    begin sel_soft_reset = soft_reset_2; sel_empty_q = fifo_empty_2; end
         default: begin sel_soft_reset = 1'b0;         sel_empty_q = 1'b0;         end
      endcase
      case (data_in)
         2'd0:    hdr_empty = fifo_empty_0;
         2'd1:    hdr_empty = fifo_empty_1;
         2'd2:    hdr_empty = fifo_empty_2;
         default: hdr_empty = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= DECODE_ADDRESS;
         addr_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      if (state_q == DECODE_ADDRESS && pkt_valid && data_in != 2'b11) begin
         addr_d = data_in;
      end
      if (sel_soft_reset && state_q != DECODE_ADDRESS) begin
         state_d = DECODE_ADDRESS;
      end else begin
         case (state_q)
            DECODE_ADDRESS: begin
               if (pkt_valid && data_in != 2'b11) begin
                  state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
               end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
               if (fifo_full)       state_d = FIFO_FULL_STATE;
               else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
               if (!fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
               if (parity_done)        state_d = DECODE_ADDRESS;
               else if (low_pkt_valid) state_d = LOAD_PARITY;
               else                    state_d = LOAD_DATA;
            end
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY: begin
               if (sel_empty_q) state_d = LOAD_FIRST_DATA;
            end
            default:            state_d = DECODE_ADDRESS;
         endcase
      end
   end

   always_comb begin
      busy          = 1'b0;
      detect_add    = 1'b0;
      lfd_state     = 1'b0;
      ld_state      = 1'b0;
      laf_state     = 1'b0;
      full_state    = 1'b0;
      write_enb_reg = 1'b0;
      rst_int_reg   = 1'b0;
      case (state_q)
         DECODE_ADDRESS:     detect_add = 1'b1;
         LOAD_FIRST_DATA:    begin lfd_state = 1'b1; busy = 1'b1; write_enb_reg = 1'b1; end
         LOAD_DATA:          begin ld_state = 1'b1; write_enb_reg = 1'b1; end
         FIFO_FULL_STATE:    begin full_state = 1'b1; busy = 1'b1; end
         LOAD_AFTER_FULL:    begin laf_state = 1'b1; busy = 1'b1; write_enb_reg = 1'b1; end
         LOAD_PARITY:        begin busy = 1'b1; write_enb_reg = 1'b1; end
         CHECK_PARITY_ERROR: begin rst_int_reg = 1'b1; busy = 1'b1; end
         WAIT_TILL_EMPTY:    busy = 1'b1;
         default:            detect_add = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_router_fsm.sv
// tb/tb_router_fsm.sv - directed vector bench for router_fsm
module tb_router_fsm;

   // Output bits: {busy, detect_add, lfd, ld, laf, full, write_enb, rst_int}
   localparam logic [7:0] O_DA  = 8'b0100_0000;
   localparam logic [7:0] O_LFD = 8'b1010_0010;
   localparam logic [7:0] O_LD  = 8'b0001_0010;
   localparam logic [7:0] O_FFS = 8'b1000_0100;
   localparam logic [7:0] O_LAF = 8'b1000_1010;
   localparam logic [7:0] O_LP  = 8'b1000_0010;
   localparam logic [7:0] O_CPE = 8'b1000_0001;
   localparam logic [7:0] O_WTE = 8'b1000_0000;

   typedef struct {
      logic       pv;
      logic [1:0] din;
      logic       pd;
      logic       lpv;
      logic       full;
      logic [2:0] emp;
      logic [2:0] srst;
      logic [7:0] exp;
   } vec_t;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       pkt_valid = 1'b0;
   logic [1:0] data_in = 2'd0;
   logic       parity_done = 1'b0;
   logic       low_pkt_valid = 1'b0;
   logic       fifo_full = 1'b0;
   logic [2:0] emp = 3'b000;
   logic [2:0] srst = 3'b000;
   logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
   logic       write_enb_reg, rst_int_reg;
   logic [7:0] outs;

   int n_vec = 0;
   int n_err = 0;
   vec_t vecs[$];

   always #5 clock = ~clock;

   router_fsm dut (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
      .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
      .fifo_empty_0(emp[0]), .fifo_empty_1(emp[1]), .fifo_empty_2(emp[2]),
      .soft_reset_0(srst[0]), .soft_reset_1(srst[1]), .soft_reset_2(srst[2]),
      .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
      .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
      .rst_int_reg(rst_int_reg)
   );

   assign outs = {busy, detect_add, lfd_state, ld_state, laf_state, full_state,
                  write_enb_reg, rst_int_reg};

   task automatic add(input logic pv, input logic [1:0] din, input logic pd, input logic lpv,
                      input logic full, input logic [2:0] e, input logic [2:0] s,
                      input logic [7:0] x);
      vec_t v;
      v.pv = pv; v.din = din; v.pd = pd; v.lpv = lpv; v.full = full;
      v.emp = e; v.srst = s; v.exp = x;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [7:0] exp_o);
      n_vec++;
      if (outs !== exp_o) begin
         n_err++;
         $display("FAIL %s: outputs got %b expected %b", name, outs, exp_o);
      end
   endtask

   task automatic drive(input vec_t v);
      pkt_valid = v.pv; data_in = v.din; parity_done = v.pd;
      low_pkt_valid = v.lpv; fifo_full = v.full; emp = v.emp; srst = v.srst;
   endtask

   initial begin
      //   pv din pd lpv full emp     srst    expected-after-edge
      // normal packet to port 1: LFD, LD x3, LP, CPE, DA
      add(1, 2'd1, 0, 0, 0, 3'b010, 3'b000, O_LFD);
      add(1, 2'd1, 0, 0, 0, 3'b010, 3'b000, O_LD);
      add(1, 2'd1, 0, 0, 0, 3'b010, 3'b000, O_LD);
      add(1, 2'd1, 0, 0, 0, 3'b010, 3'b000, O_LD);
      add(0, 2'd1, 0, 0, 0, 3'b010, 3'b000, O_LP);
      add(0, 2'd1, 0, 0, 0, 3'b010, 3'b000, O_CPE);
      add(0, 2'd1, 0, 0, 0, 3'b010, 3'b000, O_DA);
      // invalid address stays in decode
      add(1, 2'd3, 0, 0, 0, 3'b111, 3'b000, O_DA);
      // busy target port 0: other empties ignored
      add(1, 2'd0, 0, 0, 0, 3'b000, 3'b000, O_WTE);
      add(1, 2'd0, 0, 0, 0, 3'b010, 3'b000, O_WTE);
      add(1, 2'd0, 0, 0, 0, 3'b011, 3'b000, O_LFD);
      add(1, 2'd0, 0, 0, 0, 3'b011, 3'b000, O_LD);
      add(0, 2'd0, 0, 0, 0, 3'b011, 3'b000, O_LP);
      add(0, 2'd0, 0, 0, 0, 3'b011, 3'b000, O_CPE);
      add(0, 2'd0, 0, 0, 0, 3'b011, 3'b000, O_DA);
      // port 2 full stall x4, release to LAF, back to LD
      add(1, 2'd2, 0, 0, 0, 3'b100, 3'b000, O_LFD);
      add(1, 2'd2, 0, 0, 0, 3'b100, 3'b000, O_LD);
      add(1, 2'd2, 0, 0, 1, 3'b100, 3'b000, O_FFS);
      add(1, 2'd2, 0, 0, 1, 3'b100, 3'b000, O_FFS);
      add(1, 2'd2, 0, 0, 1, 3'b100, 3'b000, O_FFS);
      add(1, 2'd2, 0, 0, 1, 3'b100, 3'b000, O_FFS);
      add(1, 2'd2, 0, 0, 0, 3'b100, 3'b000, O_LAF);
      add(1, 2'd2, 0, 0, 0, 3'b100, 3'b000, O_LD);
      // full then low_pkt_valid: LAF, LP, CPE
      add(1, 2'd2, 0, 0, 1, 3'b100, 3'b000, O_FFS);
      add(1, 2'd2, 0, 1, 0, 3'b100, 3'b000, O_LAF);
      add(0, 2'd2, 0, 1, 0, 3'b100, 3'b000, O_LP);
      add(0, 2'd2, 0, 0, 0, 3'b100, 3'b000, O_CPE);
      add(0, 2'd2, 0, 0, 0, 3'b100, 3'b000, O_DA);
      // full beats !pkt_valid; parity_done from LAF goes straight home
      add(1, 2'd2, 0, 0, 0, 3'b100, 3'b000, O_LFD);
      add(1, 2'd2, 0, 0, 0, 3'b100, 3'b000, O_LD);
      add(0, 2'd2, 0, 0, 1, 3'b100, 3'b000, O_FFS);
      add(0, 2'd2, 1, 0, 0, 3'b100, 3'b000, O_LAF);
      add(0, 2'd2, 1, 1, 0, 3'b100, 3'b000, O_DA);
      // CPE with full -> FFS, then soft reset wins over full
      add(1, 2'd2, 0, 0, 0, 3'b100, 3'b000, O_LFD);
      add(0, 2'd2, 0, 0, 0, 3'b100, 3'b000, O_LD);
      add(0, 2'd2, 0, 0, 0, 3'b100, 3'b000, O_LP);
      add(0, 2'd2, 0, 0, 1, 3'b100, 3'b000, O_CPE);
      add(0, 2'd2, 0, 0, 1, 3'b100, 3'b000, O_FFS);
      add(0, 2'd2, 0, 0, 1, 3'b100, 3'b100, O_DA);
      // soft reset in WTE for port 2: wrong port ignored
      add(1, 2'd2, 0, 0, 0, 3'b000, 3'b000, O_WTE);
      add(0, 2'd2, 0, 0, 0, 3'b000, 3'b001, O_WTE);
      add(0, 2'd2, 0, 0, 0, 3'b000, 3'b100, O_DA);
      add(0, 2'd0, 0, 0, 0, 3'b000, 3'b111, O_DA);
      // soft reset out of LFD for port 1
      add(1, 2'd1, 0, 0, 0, 3'b010, 3'b000, O_LFD);
      add(1, 2'd1, 0, 0, 0, 3'b010, 3'b010, O_DA);

      // reset state
      repeat (2) @(posedge clock);
      #1 check("reset_state", O_DA);
      resetn = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         @(posedge clock);
         #1 check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // asynchronous reset while in LOAD_DATA
      pkt_valid = 1'b1; data_in = 2'd1; emp = 3'b010; srst = 3'b000;
      fifo_full = 1'b0; parity_done = 1'b0; low_pkt_valid = 1'b0;
      @(posedge clock); #1 check("arst_lfd", O_LFD);
      @(posedge clock); #1 check("arst_ld", O_LD);
      #2 resetn = 1'b0;
      #1 check("arst_immediate", O_DA);
      @(posedge clock); #1 check("arst_held", O_DA);
      resetn = 1'b1;
      // after reset addr_reg is 0: soft_reset_0 must not affect decode, then
      // a port-0 wait shows the new header is honoured
      pkt_valid = 1'b1; data_in = 2'd0; emp = 3'b000;
      @(posedge clock); #1 check("post_rst_wte", O_WTE);
      srst = 3'b001;
      @(posedge clock); #1 check("post_rst_srst0", O_DA);
      srst = 3'b000; pkt_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Control FSM for the 1x3 router.
- Sequences reception of one packet per pass: header byte (address), payload, parity byte.
- Drives the write-side datapath strobes (detect_add, lfd/ld/laf/full_state, write_enb_reg, rst_int_reg) and the busy back-pressure to the source.
- Consumes FIFO status and per-port soft resets from the synchronizer.

Parameters:
none (3 output ports, 2-bit address fixed)

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- pkt_valid  in  1  source has valid header/payload byte on bus
- data_in  in  2  address field of header byte (bits [1:0])
- parity_done  in  1  register block has captured parity byte
- low_pkt_valid  in  1  pkt_valid fell while FIFO was full (parity pending)
- fifo_full  in  1  selected FIFO full (from synchronizer)
- fifo_empty_0, fifo_empty_1, fifo_empty_2  in  1 each  per-port FIFO empty
- soft_reset_0, soft_reset_1, soft_reset_2  in  1 each  per-port timeout reset
- busy  out  1  stall source; do not present new byte
- detect_add  out  1  header decode cycle; synchronizer latches address
- lfd_state  out  1  loading header byte into FIFO
- ld_state  out  1  loading payload
- laf_state  out  1  loading held byte after full
- full_state  out  1  waiting on full FIFO
- write_enb_reg  out  1  FIFO write request
- rst_int_reg  out  1  clear internal parity/error registers

Behaviour:
- State register updates on the rising clock edge. resetn=0 forces DECODE_ADDRESS asynchronously and clears addr_reg to 0.
- All outputs are Moore, decoded combinationally from state. Under reset: detect_add=1, all other outputs 0.
- addr_reg (2b): loaded with data_in when state==DECODE_ADDRESS && pkt_valid && data_in!=2'b11. Holds otherwise.
- Soft reset:
  - sel_soft_reset = soft_reset_[addr_reg].
  - If asserted, next state = DECODE_ADDRESS from every state except DECODE_ADDRESS itself.
  - Has highest priority over all transitions below.
- DECODE_ADDRESS:
  - Outputs: detect_add=1.
  - pkt_valid && data_in==k (k in 0..2) && fifo_empty_k -> LOAD_FIRST_DATA.
  - pkt_valid && data_in==k && !fifo_empty_k -> WAIT_TILL_EMPTY.
  - data_in==3 or !pkt_valid -> stay; invalid address is ignored and addr_reg is unchanged.
- LOAD_FIRST_DATA:
  - Outputs: lfd_state=1, busy=1, write_enb_reg=1.
  - Always -> LOAD_DATA. Exactly one cycle.
- LOAD_DATA:
  - Outputs: ld_state=1, write_enb_reg=1, busy=0.
  - fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
  - fifo_full has priority over !pkt_valid.
- FIFO_FULL_STATE:
  - Outputs: full_state=1, busy=1, write_enb_reg=0.
  - !fifo_full -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL:
  - Outputs: laf_state=1, busy=1, write_enb_reg=1.
  - parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
- LOAD_PARITY:
  - Outputs: busy=1, write_enb_reg=1.
  - Always -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR:
  - Outputs: rst_int_reg=1, busy=1.
  - fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- WAIT_TILL_EMPTY:
  - Outputs: busy=1, write_enb_reg=0.
  - fifo_empty_[addr_reg] -> LOAD_FIRST_DATA; else stay.
  - Empties of other ports are ignored.
- Exactly one of detect_add/lfd_state/ld_state/laf_state/full_state/rst_int_reg is high in its state; all are 0 elsewhere.
- Unused state encodings -> DECODE_ADDRESS.
- Minimum packet latency, header to return to DECODE_ADDRESS with no full: 1 (LFD) + N payload + 1 (LP) + 1 (CPE) cycles.

Test Plan:
- Reset mid-packet: drive resetn=0 asynchronously while in LOAD_DATA -> state DECODE_ADDRESS immediately, detect_add=1, busy=0, write_enb_reg=0, addr_reg=0.
- Normal packet: fifo_empty_1=1, pkt_valid=1, data_in=01, 3 payload cycles, then pkt_valid=0 -> sequence DA, LFD, LD x3, LP, CPE, DA; rst_int_reg=1 for exactly one cycle; addr_reg=1.
- Full stall: in LOAD_DATA for port 2, assert fifo_full for 4 cycles, release with parity_done=0 and low_pkt_valid=0 -> FFS x4 (busy=1, write_enb_reg=0), LAF x1, back to LD.
- Full then parity: same as previous but low_pkt_valid=1 at release -> LAF, LP, CPE. Repeat with parity_done=1 -> LAF, DA.
- Busy target: fifo_empty_0=0, header data_in=00 -> WAIT_TILL_EMPTY with busy=1. Set fifo_empty_1=1: no change. Set fifo_empty_0=1 -> LFD next cycle.
- Soft reset/invalid address:
  - In WAIT_TILL_EMPTY for port 2, pulse soft_reset_2 -> DA next cycle. Pulsing soft_reset_0 instead has no effect.
  - data_in=11 with pkt_valid=1 -> remains in DA, addr_reg unchanged.
